// File: rtl/ie_mult_div_unit.sv
// Iterative execute-stage multiply/divide unit holding the architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, with a sign-fix cycle before writeback.
module ie_mult_div_unit #(
  parameter int NB_INST  = 32,
  parameter int NB_OP    = 2,
  parameter int NB_COUNT = 6
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB_OP-1:0]   i_op,
  input  logic [NB_INST-1:0] i_operand_a,
  input  logic [NB_INST-1:0] i_operand_b,
  input  logic               i_flush,
  input  logic               i_wr_hi,
  input  logic               i_wr_lo,
  input  logic [NB_INST-1:0] i_wr_data,
  output logic [NB_INST-1:0] o_hi,
  output logic [NB_INST-1:0] o_lo,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_div_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  localparam logic [NB_COUNT-1:0] LAST_COUNT = NB_COUNT'(NB_INST - 1);

  state_t                 state, next_state;
  logic [NB_COUNT-1:0]    count;
  logic                   is_div, div_by_zero, neg_q, neg_r;
  logic [NB_INST-1:0]     mag_b;
  logic [2*NB_INST-1:0]   acc;

  logic                   start_ok, start_zero, start_signed;
  logic [NB_INST-1:0]     abs_a, abs_b;
  logic [NB_INST:0]       mul_sum, rem_shift;
  logic [NB_INST-1:0]     rem_sub;
  logic [2*NB_INST-1:0]   acc_step, acc_neg;
  logic [NB_INST-1:0]     fix_hi, fix_lo;

  assign start_ok     = (state == IDLE) && i_start && !i_flush;
  assign start_zero   = i_op[1] && (i_operand_b == '0);
  assign start_signed = !i_op[0];
  assign abs_a = (start_signed && i_operand_a[NB_INST-1]) ? -i_operand_a : i_operand_a;
  assign abs_b = (start_signed && i_operand_b[NB_INST-1]) ? -i_operand_b : i_operand_b;

  // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide
  assign mul_sum   = {1'b0, acc[2*NB_INST-1:NB_INST]} + (acc[0] ? {1'b0, mag_b} : '0);
  assign rem_shift = acc[2*NB_INST-1:NB_INST-1];
  assign rem_sub   = rem_shift[NB_INST-1:0] - mag_b;

  always_comb begin
    acc_step = {mul_sum, acc[NB_INST-1:1]};
    if (is_div) begin
      if (rem_shift >= {1'b0, mag_b})
        acc_step = {rem_sub, acc[NB_INST-2:0], 1'b1};
      else
        acc_step = {rem_shift[NB_INST-1:0], acc[NB_INST-2:0], 1'b0};
    end
  end

  assign acc_neg = -acc;

  always_comb begin
    fix_hi = neg_q ? acc_neg[2*NB_INST-1:NB_INST] : acc[2*NB_INST-1:NB_INST];
    fix_lo = neg_q ? acc_neg[NB_INST-1:0] : acc[NB_INST-1:0];
    if (div_by_zero) begin
      fix_hi = acc[2*NB_INST-1:NB_INST];
      fix_lo = acc[NB_INST-1:0];
    end else if (is_div) begin
      fix_hi = neg_r ? -acc[2*NB_INST-1:NB_INST] : acc[2*NB_INST-1:NB_INST];
      fix_lo = neg_q ? -acc[NB_INST-1:0] : acc[NB_INST-1:0];
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start_ok) next_state = start_zero ? FIX : CALC;
      CALC: begin
        if (i_flush)                 next_state = IDLE;
        else if (count == LAST_COUNT) next_state = FIX;
      end
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) state <= IDLE;
    else         state <= next_state;
  end

  // A divide by zero skips CALC; acc is preloaded with the final {HI, LO} pattern
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      count       <= '0;
      is_div      <= 1'b0;
      div_by_zero <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      mag_b       <= '0;
      acc         <= '0;
      o_hi        <= '0;
      o_lo        <= '0;
      o_done      <= 1'b0;
      o_div_zero  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            count       <= '0;
            is_div      <= i_op[1];
            div_by_zero <= start_zero;
            neg_q       <= start_signed && (i_operand_a[NB_INST-1] ^ i_operand_b[NB_INST-1]);
            neg_r       <= start_signed && i_operand_a[NB_INST-1];
            mag_b       <= abs_b;
            acc         <= start_zero ? {i_operand_a, {NB_INST{1'b1}}}
                                      : {{NB_INST{1'b0}}, abs_a};
          end else if (!i_start) begin
            if (i_wr_hi) o_hi <= i_wr_data;
            if (i_wr_lo) o_lo <= i_wr_data;
          end
        end
        CALC: begin
          if (!i_flush) begin
            acc   <= acc_step;
            count <= count + 1'b1;
          end
        end
        FIX: begin
          if (!i_flush) begin
            o_hi   <= fix_hi;
            o_lo   <= fix_lo;
            o_done <= 1'b1;
            if (is_div) o_div_zero <= div_by_zero;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_ie_mult_div_unit.sv
// Self-checking bench for ie_mult_div_unit: random multiplies/divides against an arithmetic
// reference, plus divide-by-zero, ignored start, flush, MTHI/MTLO and mid-operation reset.
module tb_ie_mult_div_unit;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_start = 1'b0;
  logic [1:0]  i_op = 2'b00;
  logic [31:0] i_operand_a = '0;
  logic [31:0] i_operand_b = '0;
  logic        i_flush = 1'b0;
  logic        i_wr_hi = 1'b0;
  logic        i_wr_lo = 1'b0;
  logic [31:0] i_wr_data = '0;
  logic [31:0] o_hi, o_lo;
  logic        o_busy, o_done, o_div_zero;

  int errors = 0;
  int checks = 0;
  logic exp_dz = 1'b0;

  ie_mult_div_unit dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start), .i_op(i_op),
    .i_operand_a(i_operand_a), .i_operand_b(i_operand_b), .i_flush(i_flush),
    .i_wr_hi(i_wr_hi), .i_wr_lo(i_wr_lo), .i_wr_data(i_wr_data),
    .o_hi(o_hi), .o_lo(o_lo), .o_busy(o_busy), .o_done(o_done), .o_div_zero(o_div_zero)
  );

  always #5 i_clock = ~i_clock;

  // Returns {HI, LO} as the architecture defines them, from plain integer arithmetic
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    logic [63:0] res;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    res = '0;
    case (op)
      2'd0: begin q = sa * sb; res = q; end
      2'd1: begin uq = ua * ub; res = uq; end
      2'd2: begin
        if (b == 0) res = {a, 32'hFFFFFFFF};
        else begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
      end
      default: begin
        if (b == 0) res = {a, 32'hFFFFFFFF};
        else begin uq = ua / ub; ur = ua % ub; res = {ur[31:0], uq[31:0]}; end
      end
    endcase
    return res;
  endfunction

  // Launches one operation (start sampled at edge 0) and reports where busy/done were seen
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int busy_first, output int busy_last, output int done_at);
    @(negedge i_clock);
    i_start = 1'b1; i_op = op; i_operand_a = a; i_operand_b = b;
    @(posedge i_clock);
    @(negedge i_clock);
    i_start = 1'b0;
    busy_first = 0; busy_last = 0; done_at = 0;
    for (int c = 1; c <= 60; c++) begin
      if (c > 1) @(negedge i_clock);
      if (o_busy) begin
        if (busy_first == 0) busy_first = c;
        busy_last = c;
      end
      if (o_done) begin
        done_at = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    i_reset = 1'b1;
    repeat (3) @(negedge i_clock);
    checks++;
    if ({o_busy, o_done, o_div_zero} !== 3'b000 || o_hi !== 32'h0 || o_lo !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_state: busy=%b done=%b dz=%b hi=%h lo=%h, need all zero",
               o_busy, o_done, o_div_zero, o_hi, o_lo);
    end
    i_reset = 1'b0;
    exp_dz = 1'b0;
  endtask

  task automatic check_result(input string name, input logic [1:0] op, input logic [31:0] a,
                              input logic [31:0] b, input int bf, input int bl, input int da);
    logic [63:0] exp;
    exp = model(op, a, b);
    checks++;
    if (!(bf == 1 && bl == 33 && da == 34)) begin
      errors++;
      $display("[TB] FAIL %s_timing: busy %0d..%0d done %0d, need busy 1..33 done 34", name, bf, bl, da);
    end
    checks++;
    if ({o_hi, o_lo} !== exp) begin
      errors++;
      $display("[TB] FAIL %s_result op=%0d a=%h b=%h: hi=%h lo=%h, need hi=%h lo=%h",
               name, op, a, b, o_hi, o_lo, exp[63:32], exp[31:0]);
    end
    checks++;
    if (o_div_zero !== exp_dz) begin
      errors++;
      $display("[TB] FAIL %s_div_zero: got %b, need %b", name, o_div_zero, exp_dz);
    end
  endtask

  task automatic test_multiply;
    int bf, bl, da;
    logic [1:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 12; i++) begin
      op = 2'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      if (i == 0) begin op = 2'd1; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; end
      if (i == 1) begin op = 2'd0; a = 32'hFFFFFFFD; b = 32'd7; end
      if (i == 2) begin op = 2'd0; a = 32'h80000000; b = 32'h80000000; end
      run_op(op, a, b, bf, bl, da);
      check_result("mult", op, a, b, bf, bl, da);
    end
  endtask

  task automatic test_divide;
    int bf, bl, da;
    logic [1:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 12; i++) begin
      op = 2'($urandom_range(2, 3));
      a = $urandom;
      b = (i % 2 == 0) ? 32'($urandom_range(1, 15)) : $urandom;
      if (b == 0) b = 32'd1;
      if (i == 0) begin op = 2'd2; a = 32'hFFFFFFF9; b = 32'd2; end
      if (i == 1) begin op = 2'd3; a = 32'd7; b = 32'd2; end
      if (i == 2) begin op = 2'd2; a = 32'd100; b = 32'hFFFFFFF9; end
      exp_dz = 1'b0;
      run_op(op, a, b, bf, bl, da);
      check_result("div", op, a, b, bf, bl, da);
    end
  endtask

  task automatic test_div_zero;
    int bf, bl, da;
    logic [31:0] a;
    for (int i = 0; i < 2; i++) begin
      a = (i == 0) ? 32'h00001234 : $urandom;
      run_op((i == 0) ? 2'd3 : 2'd2, a, 32'h0, bf, bl, da);
      checks++;
      if (!(bf == 1 && bl == 1 && da == 2)) begin
        errors++;
        $display("[TB] FAIL divzero_timing: busy %0d..%0d done %0d, need busy 1..1 done 2", bf, bl, da);
      end
      checks++;
      if (o_lo !== 32'hFFFFFFFF || o_hi !== a || o_div_zero !== 1'b1) begin
        errors++;
        $display("[TB] FAIL divzero_result: hi=%h lo=%h dz=%b, need hi=%h lo=ffffffff dz=1",
                 o_hi, o_lo, o_div_zero, a);
      end
    end
    exp_dz = 1'b1;
    run_op(2'd1, 32'd9, 32'd9, bf, bl, da);
    check_result("mult_after_dz", 2'd1, 32'd9, 32'd9, bf, bl, da);
    exp_dz = 1'b0;
    run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, bf, bl, da);
    check_result("div_overflow", 2'd2, 32'h80000000, 32'hFFFFFFFF, bf, bl, da);
    checks++;
    if (o_lo !== 32'h80000000 || o_hi !== 32'h0) begin
      errors++;
      $display("[TB] FAIL div_overflow_const: hi=%h lo=%h, need hi=00000000 lo=80000000", o_hi, o_lo);
    end
  endtask

  task automatic test_ignore_start_and_flush;
    int da;
    int done_seen;
    @(negedge i_clock);
    i_start = 1'b1; i_op = 2'd1; i_operand_a = 32'd5; i_operand_b = 32'd6;
    @(posedge i_clock);
    @(negedge i_clock);
    i_start = 1'b0;
    da = 0;
    for (int c = 1; c <= 60; c++) begin
      if (c > 1) @(negedge i_clock);
      if (c == 4) begin i_start = 1'b1; i_op = 2'd3; i_operand_a = 32'd100; i_operand_b = 32'd3; end
      if (c == 6) i_start = 1'b0;
      if (o_done) begin da = c; break; end
    end
    checks++;
    if (da != 34 || o_hi !== 32'h0 || o_lo !== 32'd30) begin
      errors++;
      $display("[TB] FAIL ignore_start: done %0d hi=%h lo=%h, need done 34 hi=0 lo=1e", da, o_hi, o_lo);
    end

    @(negedge i_clock);
    i_start = 1'b1; i_op = 2'd0; i_operand_a = $urandom; i_operand_b = $urandom;
    @(posedge i_clock);
    @(negedge i_clock);
    i_start = 1'b0;
    done_seen = 0;
    for (int c = 1; c <= 50; c++) begin
      if (c > 1) @(negedge i_clock);
      if (o_done) done_seen++;
      if (c == 10) i_flush = 1'b1;
      if (c == 11) begin
        i_flush = 1'b0;
        checks++;
        if (o_busy !== 1'b0) begin
          errors++;
          $display("[TB] FAIL flush_busy: busy=%b at cycle 11, need 0", o_busy);
        end
      end
    end
    checks++;
    if (done_seen != 0 || o_hi !== 32'h0 || o_lo !== 32'd30) begin
      errors++;
      $display("[TB] FAIL flush_result: done pulses %0d hi=%h lo=%h, need 0 pulses hi=0 lo=1e",
               done_seen, o_hi, o_lo);
    end
  endtask

  task automatic test_mthi_mtlo;
    int da;
    @(negedge i_clock);
    i_wr_hi = 1'b1; i_wr_lo = 1'b1; i_wr_data = 32'hCAFEF00D;
    @(negedge i_clock);
    i_wr_hi = 1'b0; i_wr_lo = 1'b0;
    checks++;
    if (o_hi !== 32'hCAFEF00D || o_lo !== 32'hCAFEF00D) begin
      errors++;
      $display("[TB] FAIL mthi_mtlo: hi=%h lo=%h, need cafef00d both", o_hi, o_lo);
    end
    i_start = 1'b1; i_op = 2'd1; i_operand_a = 32'd2; i_operand_b = 32'd3;
    i_wr_lo = 1'b1; i_wr_data = 32'h11111111;
    @(negedge i_clock);
    i_start = 1'b0; i_wr_lo = 1'b0;
    checks++;
    if (o_lo !== 32'hCAFEF00D || o_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mtlo_with_start: lo=%h busy=%b, need lo=cafef00d busy=1", o_lo, o_busy);
    end
    i_wr_hi = 1'b1; i_wr_data = 32'h22222222;
    @(negedge i_clock);
    i_wr_hi = 1'b0;
    checks++;
    if (o_hi !== 32'hCAFEF00D) begin
      errors++;
      $display("[TB] FAIL mthi_busy: hi=%h, need cafef00d", o_hi);
    end
    da = 0;
    for (int c = 2; c <= 60; c++) begin
      if (c > 2) @(negedge i_clock);
      if (o_done) begin da = c; break; end
    end
    checks++;
    if (da != 34 || o_hi !== 32'h0 || o_lo !== 32'd6) begin
      errors++;
      $display("[TB] FAIL mtlo_start_result: done %0d hi=%h lo=%h, need done 34 hi=0 lo=6", da, o_hi, o_lo);
    end
    i_wr_lo = 1'b1; i_wr_data = 32'h5A5A5A5A;
    @(negedge i_clock);
    i_wr_lo = 1'b0;
    checks++;
    if (o_lo !== 32'h5A5A5A5A || o_hi !== 32'h0) begin
      errors++;
      $display("[TB] FAIL mtlo_done_cycle: hi=%h lo=%h, need hi=0 lo=5a5a5a5a", o_hi, o_lo);
    end
  endtask

  task automatic test_reset_mid_op;
    int bf, bl, da;
    int done_seen;
    run_op(2'd3, 32'd5, 32'd0, bf, bl, da);
    @(negedge i_clock);
    i_start = 1'b1; i_op = 2'd0; i_operand_a = $urandom; i_operand_b = $urandom;
    @(posedge i_clock);
    @(negedge i_clock);
    i_start = 1'b0;
    done_seen = 0;
    for (int c = 1; c <= 50; c++) begin
      if (c > 1) @(negedge i_clock);
      if (o_done) done_seen++;
      if (c == 15) i_reset = 1'b1;
      if (c == 16) begin
        i_reset = 1'b0;
        checks++;
        if ({o_busy, o_done, o_div_zero} !== 3'b000 || o_hi !== 32'h0 || o_lo !== 32'h0) begin
          errors++;
          $display("[TB] FAIL reset_mid_op: busy=%b done=%b dz=%b hi=%h lo=%h, need all zero",
                   o_busy, o_done, o_div_zero, o_hi, o_lo);
        end
      end
    end
    checks++;
    if (done_seen != 0) begin
      errors++;
      $display("[TB] FAIL reset_no_done: %0d done pulses, need 0", done_seen);
    end
    exp_dz = 1'b0;
    run_op(2'd1, 32'd2, 32'd3, bf, bl, da);
    check_result("after_reset", 2'd1, 32'd2, 32'd3, bf, bl, da);
  endtask

  initial begin
    test_reset;
    test_multiply;
    test_divide;
    test_div_zero;
    test_ignore_start_and_flush;
    test_mthi_mtlo;
    test_reset_mid_op;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ie_mult_div_unit.md
Name: ie_mult_div_unit

Overview:
Execute-stage iterative multiply/divide unit. It sits directly downstream of the operand-A and operand-B multiplexors and consumes their 32-bit outputs for MULT/MULTU/DIV/DIVU. It holds the architectural HI/LO registers, which are written by MTHI/MTLO and read by MFHI/MFLO. It provides a start/busy/done handshake that the hazard unit uses to stall the pipeline.

Parameters:
NB_INST, 32, operand/HI/LO width
NB_OP, 2, operation selector width
NB_COUNT, 6, iteration counter width (must hold NB_INST)

Ports:
i_clock  input  1  system clock, all state updates on rising edge
i_reset  input  1  synchronous, active-high reset
i_start  input  1  start request; sampled only in IDLE
i_op  input  NB_OP  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with i_start
i_operand_a  input  NB_INST  multiplicand / dividend (from operand-A mux)
i_operand_b  input  NB_INST  multiplier / divisor (from operand-B mux)
i_flush  input  1  abort in-flight operation
i_wr_hi  input  1  MTHI write enable
i_wr_lo  input  1  MTLO write enable
i_wr_data  input  NB_INST  MTHI/MTLO data
o_hi  output  NB_INST  HI register
o_lo  output  NB_INST  LO register
o_busy  output  1  operation in progress
o_done  output  1  one-cycle pulse; HI/LO hold the new result in this cycle
o_div_zero  output  1  registered flag; set when the last DIV/DIVU had divisor 0

Behaviour:
- Clock and reset: one clock, i_clock. Reset is synchronous and active-high on i_reset.
- Reset values: state IDLE; o_hi, o_lo, o_busy, o_done, o_div_zero, counter and internal accumulators all 0.
- Reset mid-operation: returns to IDLE on the next edge. No o_done pulse. HI/LO cleared.
- FSM states: IDLE, CALC, FIX.
  - IDLE -> CALC on i_start with a multiply, or a divide with nonzero divisor.
  - IDLE -> FIX on i_start with DIV/DIVU and i_operand_b == 0.
  - CALC -> FIX after NB_INST iterations.
  - FIX -> IDLE always.
- Start capture: at start, latch op, operand magnitudes (absolute value for MULT/DIV, raw for MULTU/DIVU) and result sign.
  - Product sign = a[31]^b[31].
  - Quotient sign = a[31]^b[31]; remainder sign = a[31].
- CALC: one iteration per cycle, counter 0..NB_INST-1.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring, one quotient bit per cycle.
- FIX: apply sign correction (two's-complement negate of the 64-bit product, quotient or remainder as required). Write HI/LO at the end of FIX.
  - Multiply: HI = product[63:32], LO = product[31:0].
  - Divide: LO = quotient, HI = remainder.
- Latency: i_start sampled at edge 0.
  - Normal operation: o_busy high in cycles 1..33; o_done high in cycle 34 with o_busy low.
  - Divide by zero: o_busy high in cycle 1 only; o_done in cycle 2.
- Divide by zero: LO = all ones, HI = i_operand_a (unsigned and signed alike). o_div_zero = 1.
- o_div_zero update: changes only when a divide completes (0 on a nonzero divide). Unchanged by multiplies.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- i_start while busy: ignored; the operation is not queued.
- i_flush while busy: return to IDLE on the next edge. No o_done. HI/LO keep their prior values. Flush in IDLE has no effect.
- i_flush and i_start in the same IDLE cycle: flush wins; start is dropped.
- MTHI/MTLO: in IDLE, i_wr_hi/i_wr_lo load i_wr_data on the next edge; both may be asserted together.
  - Writes while busy are ignored.
  - Write and i_start in the same cycle: start wins, write dropped.
  - A write in the o_done cycle is accepted (unit is IDLE) and overwrites the result.
- o_hi/o_lo: driven directly from registers; no combinational path from inputs.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF, start at edge 0 -> o_busy cycles 1..33; o_done cycle 34; HI=0xFFFFFFFE, LO=0x00000001.
- MULT a=0xFFFFFFFD (-3), b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIVU a=7, b=2 -> LO=3, HI=1; o_div_zero=0.
- DIVU a=0x00001234, b=0 -> o_busy cycle 1 only; o_done cycle 2; LO=0xFFFFFFFF, HI=0x00001234, o_div_zero=1. Then DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0, o_div_zero=0.
- Start MULTU 5*6. Re-assert i_start with different operands at cycle 5 -> ignored; result HI=0, LO=30. Start another op and raise i_flush at cycle 10 -> o_busy low at cycle 11; no o_done; HI=0, LO=30 retained.
- In IDLE, i_wr_hi=1, i_wr_lo=1, i_wr_data=0xCAFEF00D -> HI=LO=0xCAFEF00D next cycle. i_wr_lo together with i_start -> write dropped. i_wr_hi during busy -> ignored.
- Start MULT, assert i_reset at cycle 15 -> cycle 16: IDLE, o_busy=0, HI=LO=0, o_div_zero=0, no o_done. A subsequent MULTU 2*3 completes normally with LO=6.
